// File: rtl/mul4_seq.sv
// Sequential shift-add unsigned multiplier with a start/busy/done handshake.
// Optional MUL4_ZERO_SKIP_EN: a zero operand jumps straight from IDLE to DONE.
module mul4_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               op_busy,
  output logic               op_done,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               zero_op;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     acc_next;
  logic [WIDTH-1:0]   q_next;
  logic               last_iter;

`ifdef MUL4_ZERO_SKIP_EN
  assign zero_op = (op_a == '0) || (op_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign last_iter = (cnt_q == CntLast);

  // One shift-add step: the carry lands in acc[WIDTH] and the pair {sum, Q} shifts right.
  always_comb begin
    addend   = q_q[0] ? {1'b0, m_q} : '0;
    sum      = acc_q + addend;
    acc_next = {1'b0, sum[WIDTH:1]};
    q_next   = {sum[0], q_q[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (op_start) begin
          state_d = zero_op ? StDone : StExec;
        end
      end
      StExec: begin
        if (last_iter) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered handshake outputs follow the state being entered
  always_comb begin
    busy_d = (state_d == StExec);
    done_d = (state_d == StDone);
  end

  // Datapath next-state
  always_comb begin
    acc_d    = acc_q;
    q_d      = q_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (op_start) begin
          m_d   = op_a;
          q_d   = op_b;
          acc_d = '0;
          cnt_d = '0;
          if (zero_op) begin
            result_d = '0;
          end
        end
      end
      StExec: begin
        acc_d = acc_next;
        q_d   = q_next;
        cnt_d = cnt_q + CntW'(1);
        if (last_iter) begin
          result_d = {acc_next[WIDTH-1:0], q_next};
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      q_q      <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      q_q      <= q_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign op_busy = busy_q;
  assign op_done = done_q;
  assign result  = result_q;

endmodule
